// File: rtl/upd_pkg.sv
// Shared types and constants for the upd77c25 firmware loader.
package upd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPgm,
    StDat,
    StDone
  } upd_state_e;

  localparam int unsigned PGM_WORD_W    = 24;
  localparam int unsigned DAT_WORD_W    = 16;
  localparam int unsigned PGM_WORDS_DEF = 2048;
  localparam int unsigned DAT_WORDS_DEF = 1024;

  // Index of the final byte of a word: 3-byte program words, 2-byte data words.
  function automatic logic [1:0] last_byte_idx(logic is_pgm);
    return is_pgm ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/upd_fw_loader_if.sv
// Byte-stream input and program/data ROM write port bundle of the firmware loader.
interface upd_fw_loader_if
  import upd_pkg::*;
#(
  parameter int unsigned PGM_AW = 11,
  parameter int unsigned DAT_AW = 10
);

  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_rdy;
  logic                  pgm_wr;
  logic [PGM_WORD_W-1:0] pgm_di;
  logic [PGM_AW-1:0]     pgm_wr_addr;
  logic                  dat_wr;
  logic [DAT_WORD_W-1:0] dat_di;
  logic [DAT_AW-1:0]     dat_wr_addr;

  // master: the loader; slave: byte source plus DSP ROM ports.
  modport master (
    input  byte_in, byte_valid,
    output byte_rdy, pgm_wr, pgm_di, pgm_wr_addr, dat_wr, dat_di, dat_wr_addr
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_rdy, pgm_wr, pgm_di, pgm_wr_addr, dat_wr, dat_di, dat_wr_addr
  );

endinterface

// File: rtl/upd_byte_packer.sv
// Little-endian byte packer: assembles 3-byte program or 2-byte data words and
// pulses word_vld (registered) the cycle after the last byte of a word is accepted.
module upd_byte_packer
  import upd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  accept,
  input  logic                  is_pgm,
  input  logic [7:0]            byte_in,
  output logic [PGM_WORD_W-1:0] word,
  output logic                  word_vld
);

  logic [1:0]            cnt_q, cnt_d;
  logic [PGM_WORD_W-1:0] word_q, word_d;
  logic                  vld_q, vld_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    vld_d  = 1'b0;
    if (clr) begin
      cnt_d = 2'd0;
    end else if (accept) begin
      unique case (cnt_q)
        2'd0:    word_d = {16'h0000, byte_in};
        2'd1:    word_d[15:8] = byte_in;
        default: word_d[23:16] = byte_in;
      endcase
      if (cnt_q == last_byte_idx(is_pgm)) begin
        cnt_d = 2'd0;
        vld_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word     = word_q;
  assign word_vld = vld_q;

endmodule

// File: rtl/upd_fw_loader.sv
// upd77c25 firmware loader: packs a byte stream into program then data ROM writes and
// holds the DSP in reset until the image is complete. Option: UPD_FW_LOADER_CHKSUM_EN.
module upd_fw_loader
  import upd_pkg::*;
#(
  parameter int unsigned PGM_AW    = 11,
  parameter int unsigned DAT_AW    = 10,
  parameter int unsigned PGM_WORDS = PGM_WORDS_DEF,
  parameter int unsigned DAT_WORDS = DAT_WORDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  upd_fw_loader_if.master  bus,
  output logic             dsp_rst,
  output logic             busy,
  output logic             done
`ifdef UPD_FW_LOADER_CHKSUM_EN
  ,
  output logic [15:0]      chksum,
  input  logic [15:0]      exp_sum,
  output logic             chk_err
`endif
);

  localparam logic [PGM_AW-1:0] PgmLast = PGM_AW'(PGM_WORDS - 1);
  localparam logic [DAT_AW-1:0] DatLast = DAT_AW'(DAT_WORDS - 1);

  upd_state_e            st_q, st_d;
  logic [PGM_AW-1:0]     pgm_addr_q, pgm_addr_d;
  logic [DAT_AW-1:0]     dat_addr_q, dat_addr_d;
  logic                  accept;
  logic                  word_vld;
  logic                  is_pgm;
  logic                  chk_err_int;
  logic [PGM_WORD_W-1:0] word;

  assign is_pgm = (st_q == StPgm);
  // No byte is taken on a strobe cycle, which keeps the packed word stable for the write.
  assign bus.byte_rdy = ((st_q == StPgm) || (st_q == StDat)) && !word_vld;
  assign accept       = bus.byte_valid && bus.byte_rdy && !start;

  upd_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .accept   (accept),
    .is_pgm   (is_pgm),
    .byte_in  (bus.byte_in),
    .word     (word),
    .word_vld (word_vld)
  );

  assign bus.pgm_wr      = word_vld && (st_q == StPgm);
  assign bus.dat_wr      = word_vld && (st_q == StDat);
  assign bus.pgm_di      = word;
  assign bus.dat_di      = word[DAT_WORD_W-1:0];
  assign bus.pgm_wr_addr = pgm_addr_q;
  assign bus.dat_wr_addr = dat_addr_q;

  always_comb begin
    st_d       = st_q;
    pgm_addr_d = pgm_addr_q;
    dat_addr_d = dat_addr_q;
    if (start) begin
      st_d       = StPgm;
      pgm_addr_d = '0;
      dat_addr_d = '0;
    end else begin
      unique case (st_q)
        StPgm: begin
          if (bus.pgm_wr) begin
            if (pgm_addr_q == PgmLast) begin
              st_d       = StDat;
              dat_addr_d = '0;
            end else begin
              pgm_addr_d = pgm_addr_q + 1'b1;
            end
          end
        end
        StDat: begin
          if (bus.dat_wr) begin
            if (dat_addr_q == DatLast) begin
              st_d = StDone;
            end else begin
              dat_addr_d = dat_addr_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= StIdle;
      pgm_addr_q <= '0;
      dat_addr_q <= '0;
    end else begin
      st_q       <= st_d;
      pgm_addr_q <= pgm_addr_d;
      dat_addr_q <= dat_addr_d;
    end
  end

`ifdef UPD_FW_LOADER_CHKSUM_EN
  logic [15:0] sum_q;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        sum_q <= sum_q + {8'h00, bus.byte_in};
      end
      // Every byte is already summed by the final data strobe.
      if (bus.dat_wr && (dat_addr_q == DatLast)) begin
        err_q <= (sum_q != exp_sum);
      end
    end
  end

  assign chksum      = sum_q;
  assign chk_err     = err_q;
  assign chk_err_int = err_q;
`else
  assign chk_err_int = 1'b0;
`endif

  assign busy    = (st_q == StPgm) || (st_q == StDat);
  assign done    = (st_q == StDone);
  assign dsp_rst = !done || chk_err_int;

endmodule

// File: tb/tb_upd_fw_loader.sv
// Self-checking bench for upd_fw_loader: directed load scenarios with randomized bytes and
// valid gaps, checked each cycle against a word-list model of the loaded image.
module tb_upd_fw_loader;

  localparam int unsigned PAW = 2;
  localparam int unsigned DAW = 2;
  localparam int P = 4;
  localparam int D = 3;
  localparam int TOTAL = 3 * P + 2 * D;
`ifdef UPD_FW_LOADER_CHKSUM_EN
  localparam bit ChkOn = 1'b1;
`else
  localparam bit ChkOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic dsp_rst, busy, done;
`ifdef UPD_FW_LOADER_CHKSUM_EN
  logic [15:0] chksum;
  logic [15:0] exp_sum;
  logic        chk_err;
`endif

  always #5 clk = ~clk;

  upd_fw_loader_if #(.PGM_AW(PAW), .DAT_AW(DAW)) bus ();

  upd_fw_loader #(
    .PGM_AW    (PAW),
    .DAT_AW    (DAW),
    .PGM_WORDS (P),
    .DAT_WORDS (D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .dsp_rst (dsp_rst),
    .busy    (busy),
    .done    (done)
`ifdef UPD_FW_LOADER_CHKSUM_EN
    ,
    .chksum  (chksum),
    .exp_sum (exp_sum),
    .chk_err (chk_err)
`endif
  );

  // Model: bytes accepted since START, strobes issued, and whether a strobe is due now.
  logic [7:0] acc[$];
  bit         started;
  int         nwr;
  bit         pending;
  bit         err_exp;
  int         delta;
  logic [7:0] next_b;
  int         checks;
  int         failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit completes(input int n);
    if (n <= 3 * P) return (n % 3) == 0;
    return ((n - 3 * P) % 2) == 0;
  endfunction

  function automatic logic [23:0] exp_word(input int k);
    int base;
    if (k < P) begin
      base = 3 * k;
      return {acc[base + 2], acc[base + 1], acc[base]};
    end
    base = 3 * P + 2 * (k - P);
    return {8'h00, acc[base + 1], acc[base]};
  endfunction

  function automatic int phase();
    if (!started) return 0;
    if (nwr < P) return 1;
    if (nwr < P + D) return 2;
    return 3;
  endfunction

  function automatic bit exp_rdy();
    return ((phase() == 1) || (phase() == 2)) && !pending;
  endfunction

  function automatic logic [15:0] sum16();
    logic [15:0] s = '0;
    foreach (acc[i]) s = s + {8'h00, acc[i]};
    return s;
  endfunction

  task automatic check_outputs();
    int ph = phase();
    chk("byte_rdy", 32'(bus.byte_rdy), 32'(exp_rdy()));
    chk("pgm_wr", 32'(bus.pgm_wr), 32'(pending && nwr < P));
    chk("dat_wr", 32'(bus.dat_wr), 32'(pending && nwr >= P));
    if (pending && nwr < P) begin
      chk("pgm_wr_addr", 32'(bus.pgm_wr_addr), 32'(nwr));
      chk("pgm_di", 32'(bus.pgm_di), 32'(exp_word(nwr)));
    end
    if (pending && nwr >= P) begin
      chk("dat_wr_addr", 32'(bus.dat_wr_addr), 32'(nwr - P));
      chk("dat_di", 32'(bus.dat_di), 32'(exp_word(nwr)));
    end
    chk("busy", 32'(busy), 32'(ph == 1 || ph == 2));
    chk("done", 32'(done), 32'(ph == 3));
    chk("dsp_rst", 32'(dsp_rst), 32'(ph != 3 || err_exp));
`ifdef UPD_FW_LOADER_CHKSUM_EN
    chk("chksum", 32'(chksum), 32'(sum16()));
    chk("chk_err", 32'(chk_err), 32'(err_exp));
`endif
  endtask

  // One clock: check this cycle's outputs, drive inputs, advance the model.
  task automatic cycle(input bit v, input logic [7:0] b, input bit s, output bit took);
    check_outputs();
    took = v && exp_rdy() && !s;
    bus.byte_valid = v;
    bus.byte_in    = b;
    start          = s;
`ifdef UPD_FW_LOADER_CHKSUM_EN
    exp_sum = 16'(sum16() + 16'(delta));
`endif
    if (s) begin
      started = 1'b1;
      acc.delete();
      nwr     = 0;
      pending = 1'b0;
      err_exp = 1'b0;
    end else begin
      if (pending) begin
        nwr++;
        pending = 1'b0;
        if (nwr == P + D) err_exp = ChkOn && (delta != 0);
      end
      if (took) begin
        acc.push_back(b);
        pending = completes(acc.size());
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    started = 1'b0;
    acc.delete();
    nwr     = 0;
    pending = 1'b0;
    err_exp = 1'b0;
    chk("rst_pgm_di", 32'(bus.pgm_di), 32'h0);
    chk("rst_dat_di", 32'(bus.dat_di), 32'h0);
    chk("rst_pgm_addr", 32'(bus.pgm_wr_addr), 32'h0);
    chk("rst_dat_addr", 32'(bus.dat_wr_addr), 32'h0);
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'b0, t);
  endtask

  task automatic do_start(input bit v);
    bit t;
    cycle(v, 8'($urandom), 1'b1, t);
  endtask

  // Feed until n more bytes are accepted; incr streams 01 02 03 ... held until taken.
  task automatic feed(input int n, input int vpct, input bit incr);
    int target = acc.size() + n;
    int budget = 40 * n + 20;
    bit t;
    while (acc.size() < target && budget > 0) begin
      cycle(($urandom % 100) < vpct, incr ? next_b : 8'($urandom), 1'b0, t);
      if (t && incr) next_b++;
      budget--;
    end
    checks++;
    assert (acc.size() >= target) else begin
      failures++;
      $error("FAIL feed_timeout observed=%0d expected=%0d", acc.size(), target);
    end
  endtask

  initial begin
    bit t;
    checks   = 0;
    failures = 0;
    delta    = 0;
    next_b   = 8'h01;
    started  = 1'b0;
    nwr      = 0;
    pending  = 1'b0;
    err_exp  = 1'b0;
    bus.byte_in = 8'h00;
`ifdef UPD_FW_LOADER_CHKSUM_EN
    exp_sum = 16'h0000;
`endif
    do_reset();
    idle(2);

    // Continuous valid with an incrementing stream through a whole image.
    do_start(1'b0);
    feed(TOTAL, 100, 1'b1);
    idle(3);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0, t);

    // Random bytes and gaps; checksum expectation deliberately off by one.
    delta = 1;
    do_start(1'b1);
    feed(TOTAL, 60, 1'b0);
    idle(3);
    delta = 0;

    // Restart partway through program word 2, with a byte offered alongside START.
    do_start(1'b0);
    feed(3 * 2 + 2, 70, 1'b0);
    do_start(1'b1);
    feed(TOTAL, 80, 1'b0);
    idle(3);

    // Reset in the data phase, then a clean reload.
    do_start(1'b0);
    feed(3 * P + 3, 90, 1'b0);
    do_reset();
    idle(2);
    do_start(1'b0);
    feed(TOTAL, 50, 1'b0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
